clk_div_lock_gen: RTL and testbench
===================================

Name: clk_div_lock_gen

Overview:
- Synchronous, fabric-only clock generator used in the PHY clocking path.
- Derives up to four divided clocks from a single input clock.
- Gates its outputs behind a lock-delay counter that models PLL/MMCM lock time.
- Provides CLK0/CLK1 as live clocks and CLK2/CLK3 as optional, by default tied low, with a LOCKED status flag.

Parameters:
- LOCK_CYCLES, 16, number of CLK_IN rising edges with reset low before MMCM_LOCKED_OUT asserts; legal range 1..65535.
- OUT0_DIVIDE, 2, CLK0_OUT period in CLK_IN cycles; values <2 are treated as 2; max 256.
- OUT1_DIVIDE, 2, CLK1_OUT period in CLK_IN cycles; same rules.
- OUT2_DIVIDE, 2, CLK2_OUT period in CLK_IN cycles; same rules.
- OUT3_DIVIDE, 2, CLK3_OUT period in CLK_IN cycles; same rules.
- OUT2_EN, 0, 1 enables CLK2_OUT; 0 holds it at constant 0.
- OUT3_EN, 0, 1 enables CLK3_OUT; 0 holds it at constant 0.

Ports:
- CLK_IN  input  1  sole clock; every register updates on its rising edge.
- MMCM_RESET_IN  input  1  reset, synchronous, active-high.
- CLK0_OUT  output  1  divided clock 0, registered.
- CLK1_OUT  output  1  divided clock 1, registered.
- CLK2_OUT  output  1  divided clock 2, registered; 0 when OUT2_EN=0.
- CLK3_OUT  output  1  divided clock 3, registered; 0 when OUT3_EN=0.
- MMCM_LOCKED_OUT  output  1  lock status, registered.

Behaviour:
- Definitions: N_k = max(OUTk_DIVIDE, 2); H_k = floor(N_k/2), the number of high cycles per period.
- Reset: on any rising edge with MMCM_RESET_IN=1:
  - lock counter := 0; MMCM_LOCKED_OUT := 0.
  - all phase counters := 0; all CLKk_OUT := 0.
  - Reset has priority over everything else, including mid-operation; the next edge after reset is applied shows all outputs low.
- Lock phase: while unlocked and reset low, the lock counter increments by 1 each edge.
  - MMCM_LOCKED_OUT goes 1 on the LOCK_CYCLES-th such edge and stays 1 until reset.
  - The counter saturates once locked.
- Output generation: on the same edge MMCM_LOCKED_OUT rises, every enabled output goes 1 and its phase counter becomes 1. All outputs therefore start phase-aligned on a rising output edge.
- While locked, each edge for output k:
  - CLKk_OUT := 1 if phase_k < H_k, else 0.
  - phase_k := (phase_k + 1) mod N_k.
- Each enabled output is periodic with period N_k: high for H_k cycles, low for N_k-H_k cycles.
  - Even N gives 50% duty.
  - Odd N is high-short (e.g. N=3: 1 high, 2 low).
- Disabled outputs (OUT2_EN/OUT3_EN=0) are constant 0 in all states; their counters may be omitted.
- Glitch-free: each output changes at most once per CLK_IN edge, with no combinational path from inputs to outputs.
- Reset asserted mid-period: outputs drop to 0 on that edge regardless of phase. After deassertion the full LOCK_CYCLES wait is repeated before outputs restart at phase 0.
- Reset held high continuously: all outputs remain 0 indefinitely.
- LOCK_CYCLES=1: LOCKED and the first high output cycle occur on the first edge with reset low.
- Parameters are fixed at elaboration; there is no dynamic reconfiguration.

Test Plan:
- Defaults, reset high for 3 edges then low -> LOCKED=0 for edges 1..15 after release and =1 at edge 16. CLK0/CLK1 toggle 1,0,1,0 starting at edge 16. CLK2/CLK3 stay 0 throughout.
- OUT0_DIVIDE=4, OUT1_DIVIDE=3, LOCK_CYCLES=4 -> from lock edge, CLK0 = 1,1,0,0 repeating and CLK1 = 1,0,0 repeating. Both rise together every 12 cycles.
- OUT2_EN=1, OUT2_DIVIDE=8 -> CLK2 high 4 / low 4, rising on the lock edge aligned with CLK0.
- Reset pulsed for 1 edge while CLK0 high after lock -> all outputs and LOCKED 0 on that edge. LOCKED returns exactly LOCK_CYCLES edges after release, and outputs restart high.
- OUT0_DIVIDE=1 and OUT0_DIVIDE=0 -> behave as divide-by-2 (1,0 repeating).
- LOCK_CYCLES=1, OUT1_DIVIDE=5 -> first edge with reset low: LOCKED=1, CLK1=1. CLK1 then follows the pattern 1,1,0,0,0 (H=2).

Source files
------------

// File: rtl/clk_div_lock_gen.sv
// Fabric clock generator: four integer-divided clocks, released together
// once a lock-delay counter has modelled PLL/MMCM lock time.
module clk_div_lock_gen #(
    parameter int LOCK_CYCLES = 16,
    parameter int OUT0_DIVIDE = 2,
    parameter int OUT1_DIVIDE = 2,
    parameter int OUT2_DIVIDE = 2,
    parameter int OUT3_DIVIDE = 2,
    parameter int OUT2_EN     = 0,
    parameter int OUT3_EN     = 0
) (
    input  logic CLK_IN,
    input  logic MMCM_RESET_IN,
    output logic CLK0_OUT,
    output logic CLK1_OUT,
    output logic CLK2_OUT,
    output logic CLK3_OUT,
    output logic MMCM_LOCKED_OUT
);

    localparam int N0 = (OUT0_DIVIDE < 2) ? 2 : OUT0_DIVIDE;
    localparam int N1 = (OUT1_DIVIDE < 2) ? 2 : OUT1_DIVIDE;
    localparam int N2 = (OUT2_DIVIDE < 2) ? 2 : OUT2_DIVIDE;
    localparam int N3 = (OUT3_DIVIDE < 2) ? 2 : OUT3_DIVIDE;

    logic [15:0] lock_cnt_q, lock_cnt_d;
    logic        locked_q, locked_d;
    logic [3:0]  clk_vec;

    // locked_d is high on the lock edge itself, so outputs start on that edge
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (!locked_q) begin
            lock_cnt_d = lock_cnt_q + 16'd1;
            if (lock_cnt_d == 16'(LOCK_CYCLES)) begin
                locked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (MMCM_RESET_IN) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_out
            localparam int N_K  = (gi == 0) ? N0 : (gi == 1) ? N1 : (gi == 2) ? N2 : N3;
            localparam int H_K  = N_K / 2;
            localparam bit EN_K = (gi < 2) ? 1'b1 : (gi == 2) ? (OUT2_EN != 0) : (OUT3_EN != 0);

            if (EN_K) begin : g_on
                logic [7:0] phase_q, phase_d;
                logic       clk_q, clk_d;

                // Phase stays 0 while unlocked, so the lock edge emits phase 0 (high)
                always_comb begin
                    phase_d = phase_q;
                    clk_d   = 1'b0;
                    if (locked_d) begin
                        clk_d   = ({1'b0, phase_q} < 9'(H_K));
                        phase_d = ({1'b0, phase_q} == 9'(N_K - 1)) ? 8'd0 : phase_q + 8'd1;
                    end
                end

                always_ff @(posedge CLK_IN) begin
                    if (MMCM_RESET_IN) begin
                        phase_q <= '0;
                        clk_q   <= 1'b0;
                    end else begin
                        phase_q <= phase_d;
                        clk_q   <= clk_d;
                    end
                end

                assign clk_vec[gi] = clk_q;
            end else begin : g_off
                assign clk_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign CLK0_OUT        = clk_vec[0];
    assign CLK1_OUT        = clk_vec[1];
    assign CLK2_OUT        = clk_vec[2];
    assign CLK3_OUT        = clk_vec[3];
    assign MMCM_LOCKED_OUT = locked_q;

endmodule

// File: tb/tb_clk_div_lock_gen.sv
// Directed bench for clk_div_lock_gen: three instances with different
// divider / lock settings share one clock and one reset.
module tb_clk_div_lock_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] def_c, a_c, b_c;
    logic       def_l, a_l, b_l;
    int         errors = 0;
    int         checks = 0;

    // Instance A: LOCK=4, dividers 4,3,8,1(->2), CLK2/CLK3 enabled
    localparam int A_N [4] = '{4, 3, 8, 2};
    // Instance B: LOCK=1, dividers 0(->2),5,1(->2), CLK3 disabled
    localparam int B_N [4] = '{2, 5, 2, 2};
    localparam bit B_EN [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    clk_div_lock_gen u_def (
        .CLK_IN(clk), .MMCM_RESET_IN(rst),
        .CLK0_OUT(def_c[0]), .CLK1_OUT(def_c[1]), .CLK2_OUT(def_c[2]), .CLK3_OUT(def_c[3]),
        .MMCM_LOCKED_OUT(def_l)
    );

    clk_div_lock_gen #(
        .LOCK_CYCLES(4), .OUT0_DIVIDE(4), .OUT1_DIVIDE(3), .OUT2_DIVIDE(8), .OUT3_DIVIDE(1),
        .OUT2_EN(1), .OUT3_EN(1)
    ) u_a (
        .CLK_IN(clk), .MMCM_RESET_IN(rst),
        .CLK0_OUT(a_c[0]), .CLK1_OUT(a_c[1]), .CLK2_OUT(a_c[2]), .CLK3_OUT(a_c[3]),
        .MMCM_LOCKED_OUT(a_l)
    );

    clk_div_lock_gen #(
        .LOCK_CYCLES(1), .OUT0_DIVIDE(0), .OUT1_DIVIDE(5), .OUT2_DIVIDE(1), .OUT3_DIVIDE(7),
        .OUT2_EN(1), .OUT3_EN(0)
    ) u_b (
        .CLK_IN(clk), .MMCM_RESET_IN(rst),
        .CLK0_OUT(b_c[0]), .CLK1_OUT(b_c[1]), .CLK2_OUT(b_c[2]), .CLK3_OUT(b_c[3]),
        .MMCM_LOCKED_OUT(b_l)
    );

    // Expected divided clock: 0 before lock edge L, then high for the first
    // floor(n/2) cycles of every n-cycle period counted from L.
    function automatic logic exp_clk(int e, int lk, int n);
        if (e < lk) return 1'b0;
        return (((e - lk) % n) < (n / 2));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if ({def_c, def_l, a_c, a_l, b_c, b_l} !== 15'd0) begin
                errors++;
                $display("FAIL reset edge %0d: got def=%b/%b a=%b/%b b=%b/%b want all 0",
                         i, def_c, def_l, a_c, a_l, b_c, b_l);
            end
        end
        $display("test_reset: 3 edges checked");
    endtask

    task automatic test_default_lock();
        logic exp_t;
        rst = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            step();
            exp_t = (e >= 16) && (((e - 16) % 2) == 0);
            $display("edge %0d: def locked=%b clk=%b", e, def_l, def_c);
            checks++;
            if (def_l !== (e >= 16)) begin
                errors++;
                $display("FAIL default_locked edge %0d: got %b want %b", e, def_l, (e >= 16));
            end
            checks++;
            if (def_c !== {2'b00, exp_t, exp_t}) begin
                errors++;
                $display("FAIL default_clk edge %0d: got %b want %b", e, def_c, {2'b00, exp_t, exp_t});
            end
        end
    endtask

    task automatic test_mixed_divide();
        logic [3:0] exp_v;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            step();
            for (int k = 0; k < 4; k++) exp_v[k] = exp_clk(e, 4, A_N[k]);
            $display("edge %0d: a locked=%b clk=%b", e, a_l, a_c);
            checks++;
            if (a_l !== (e >= 4)) begin
                errors++;
                $display("FAIL mixed_locked edge %0d: got %b want %b", e, a_l, (e >= 4));
            end
            checks++;
            if (a_c !== exp_v) begin
                errors++;
                $display("FAIL mixed_clk edge %0d: got %b want %b", e, a_c, exp_v);
            end
        end
        // Period alignment: CLK0 (N=4) and CLK1 (N=3) co-rise at lock+12 = edge 16
    endtask

    task automatic test_clamp_lock1();
        logic [3:0] exp_v;
        logic [4:0] pat5;
        pat5 = 5'b00011;  // CLK1 N=5: bit i = value at phase i -> 1,1,0,0,0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            step();
            exp_v[0] = ((e - 1) % 2) == 0;
            exp_v[1] = pat5[(e - 1) % 5];
            exp_v[2] = ((e - 1) % 2) == 0;
            exp_v[3] = 1'b0;
            $display("edge %0d: b locked=%b clk=%b", e, b_l, b_c);
            checks++;
            if (b_l !== 1'b1) begin
                errors++;
                $display("FAIL lock1_locked edge %0d: got %b want 1", e, b_l);
            end
            checks++;
            if (b_c !== exp_v) begin
                errors++;
                $display("FAIL lock1_clk edge %0d: got %b want %b", e, b_c, exp_v);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp_a, exp_b;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        checks++;
        if (a_c[0] !== 1'b1 || a_l !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre a: got clk0=%b locked=%b want 1/1", a_c[0], a_l);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({def_c, def_l, a_c, a_l, b_c, b_l} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset_edge: got def=%b/%b a=%b/%b b=%b/%b want all 0",
                     def_c, def_l, a_c, a_l, b_c, b_l);
        end
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                exp_a[k] = exp_clk(e, 4, A_N[k]);
                exp_b[k] = B_EN[k] ? exp_clk(e, 1, B_N[k]) : 1'b0;
            end
            $display("edge %0d after mid reset: a=%b/%b b=%b/%b def=%b/%b", e, a_c, a_l, b_c, b_l, def_c, def_l);
            checks++;
            if ({a_l, a_c} !== {(e >= 4), exp_a}) begin
                errors++;
                $display("FAIL mid_relock_a edge %0d: got %b/%b want %b/%b", e, a_l, a_c, (e >= 4), exp_a);
            end
            checks++;
            if ({b_l, b_c} !== {1'b1, exp_b}) begin
                errors++;
                $display("FAIL mid_relock_b edge %0d: got %b/%b want 1/%b", e, b_l, b_c, exp_b);
            end
            checks++;
            if ({def_l, def_c} !== 5'd0) begin
                errors++;
                $display("FAIL mid_relock_def edge %0d: got %b/%b want 0/0000", e, def_l, def_c);
            end
        end
    endtask

    task automatic test_reset_held();
        rst = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if ({def_c, def_l, a_c, a_l, b_c, b_l} !== 15'd0) begin
                errors++;
                $display("FAIL reset_held edge %0d: got def=%b/%b a=%b/%b b=%b/%b want all 0",
                         i, def_c, def_l, a_c, a_l, b_c, b_l);
            end
        end
        $display("test_reset_held: 20 edges checked");
    endtask

    initial begin
        test_reset();
        test_default_lock();
        test_mixed_divide();
        test_clamp_lock1();
        test_mid_reset();
        test_reset_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
